// File: rtl/imm_encoder_pkg.sv
// Shared types for the instruction assembler: format codes, RV32I opcodes,
// the input field bundle and a sign-uniformity helper for range checks.
package im_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_U = 3'b010,
    FMT_B = 3'b101,
    FMT_J = 3'b110,
    FMT_R = 3'b111
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // fmt stays a raw 3-bit field so the illegal codes 011/100 can travel through.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } im_fields_t;

  // True when v[31:lsb] are all copies of the sign bit.
  function automatic logic upper_uniform(input logic [31:0] v, input int lsb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= lsb && v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational RV32I packer: scatters the immediate into format bit positions.
// IMM_RANGE_CHECK_EN adds flagging of immediates that do not fit the format.
module imm_pack
  import im_pkg::*;
(
  input  im_fields_t  fields,
  output logic [31:0] word,
  output logic        err
);

  logic        fmt_err;
  logic [31:0] imm;

  assign imm = fields.imm;

  always_comb begin
    word    = '0;
    fmt_err = 1'b0;
    case (fields.fmt)
      FMT_I: word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
      FMT_S: word = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0],
                     fields.opcode};
      FMT_U: word = {imm[31:12], fields.rd, fields.opcode};
      FMT_B: word = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                     imm[4:1], imm[11], fields.opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
      FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd,
                     fields.opcode};
      default: fmt_err = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic range_err;

  // The word is still built from the truncated bits; only the flag changes.
  always_comb begin
    range_err = 1'b0;
    case (fields.fmt)
      FMT_I, FMT_S: range_err = !upper_uniform(imm, 11);
      FMT_B:        range_err = !upper_uniform(imm, 12) || imm[0];
      FMT_J:        range_err = !upper_uniform(imm, 20) || imm[0];
      FMT_U:        range_err = (imm[11:0] != 12'd0);
      default:      range_err = 1'b0;
    endcase
  end

  assign err = fmt_err | range_err;
`else
  assign err = fmt_err;
`endif

endmodule

// File: rtl/imm_encoder.sv
// Two-stage pipelined instruction assembler with saturating handshake counters.
// Build with IMM_RANGE_CHECK_EN to also flag unrepresentable immediates.
module imm_encoder
  import im_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_imm_src,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  im_fields_t  fields;
  logic [31:0] pack_word;
  logic        pack_err;
  logic        a_valid;
  logic [31:0] a_instr;
  logic        a_err;
  logic        b_free;
  logic        out_fire;

  assign fields = '{fmt: in_imm_src, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                    rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  imm_pack u_pack (
    .fields (fields),
    .word   (pack_word),
    .err    (pack_err)
  );

  // Handshake: a transfer happens on a clock edge where valid && ready. A
  // producer holds valid and data steady until that edge; ready may depend
  // combinationally on the downstream ready, so a full pipe still moves
  // every cycle that out_ready is high.
  assign b_free   = !out_valid || out_ready;
  assign in_ready = !a_valid || b_free;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_instr   <= '0;
      a_err     <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else begin
      if (in_ready) begin
        a_valid <= in_valid;
        if (in_valid) begin
          a_instr <= pack_word;
          a_err   <= pack_err;
        end
      end
      if (b_free) begin
        out_valid <= a_valid;
        if (a_valid) begin
          out_instr <= a_instr;
          out_err   <= a_err;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_fire) begin
      if (enc_count != '1) enc_count <= enc_count + CNT_W'(1);
      if (out_err && err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed + randomized bench for imm_encoder with a scoreboard queue,
// stall/backpressure, counter saturation and mid-operation reset.
module tb_imm_encoder;
  import im_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_imm_src;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm_src(in_imm_src), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_sent   = 0;
  int n_errs   = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic uniform(input logic [31:0] v, input int lsb);
    logic [31:0] s;
    s = $signed(v) >>> lsb;
    return (s == 32'd0) || (s == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [32:0] model(input logic [2:0] fmt, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w;
    logic        e;
    w = 32'd0;
    e = 1'b0;
    case (fmt)
      3'b000: begin w = {imm[11:0], rs1, f3, rd, op}; e = RC && !uniform(imm, 11); end
      3'b001: begin w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; e = RC && !uniform(imm, 11); end
      3'b010: begin w = {imm[31:12], rd, op}; e = RC && (imm[11:0] != 12'd0); end
      3'b101: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e = RC && (!uniform(imm, 12) || imm[0]);
      end
      3'b110: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        e = RC && (!uniform(imm, 20) || imm[0]);
      end
      3'b111: w = {f7, rs2, rs1, f3, rd, op};
      default: e = 1'b1;
    endcase
    return {e, w};
  endfunction

  function automatic logic [CNT_W-1:0] sat(input int n);
    if (n >= int'(CNT_MAX)) return CNT_MAX;
    return CNT_W'(n);
  endfunction

  // scoreboard: compare the head every valid cycle (also proves hold-stability)
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) check("out_unexpected", 64'(out_valid), 64'd0);
      else begin
        check("out_word", {31'd0, out_err, out_instr}, {31'd0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  // driver tasks; called at posedge+1, return at posedge+1 after the accept edge
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic [32:0] exp,
                      input bit drain_on_stall);
    int waited = 0;
    in_imm_src = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      if (drain_on_stall) out_ready = 1'b1;
      @(negedge clk);
      waited++;
    end
    if (in_ready) begin
      exp_q.push_back(exp);
      n_sent++;
      if (exp[32]) n_errs++;
    end else check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input bit drain);
    send(fmt, op, rd, rs1, rs2, f3, f7, imm, model(fmt, op, rd, rs1, rs2, f3, f7, imm), drain);
  endtask

  task automatic check_latency(input string tag);
    int lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check(tag, 64'(lat), 64'd2);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 60) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_enc"}, 64'(enc_count), 64'(sat(n_sent)));
    check({tag, "_err"}, 64'(err_count), 64'(sat(n_errs)));
  endtask

  logic [2:0] fmt_tab [8];

  initial begin
    fmt_tab = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111, 3'b011, 3'b100};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_imm_src = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check_counters("rst");

    // I-type, all-ones immediate, with latency measurement
    send(3'b000, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, {1'b0, 32'hFFF0_0093}, 1'b0);
    check_latency("latency_first");
    wait_drain();

    // back-to-back directed formats
    send(3'b001, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, {1'b0, 32'h0020_A423}, 1'b0);
    send(3'b010, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, {1'b0, 32'h1234_52B7}, 1'b0);
    send(3'b101, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, {1'b0, 32'hFE00_0EE3}, 1'b0);
    send(3'b110, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, {1'b0, 32'h0010_00EF}, 1'b0);
    send(3'b000, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, {RC, 32'h8000_0093}, 1'b0);
    send(3'b100, OPC_OP_IMM, 5'd3, 5'd4, 5'd5, 3'd1, 7'd9, 32'h0000_0123, {1'b1, 32'h0}, 1'b0);
    send(3'b011, OPC_OP, 5'd7, 5'd8, 5'd9, 3'd2, 7'd1, 32'hDEAD_BEEF, {1'b1, 32'h0}, 1'b0);
    send(3'b111, OPC_OP, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'hFFFF_FFFF, {1'b0, 32'h4031_00B3}, 1'b0);
    wait_drain();
    check_counters("directed");

    // stall: two accepted, third refused until out_ready rises
    out_ready = 1'b0;
    send_m(3'b000, OPC_OP_IMM, 5'd10, 5'd11, 5'd0, 3'd4, 7'd0, 32'h0000_07F0, 1'b0);
    send_m(3'b001, OPC_STORE, 5'd0, 5'd12, 5'd13, 3'd2, 7'd0, 32'hFFFF_FF80, 1'b0);
    in_imm_src = 3'b010; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    send_m(3'b010, OPC_LUI, 5'd14, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 1'b1);
    wait_drain();
    check_counters("stall");

    // randomized bundles with random backpressure; drives counters to saturation
    for (int i = 0; i < 14; i++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 4095)) - 32'd2048;
      out_ready = 1'($urandom_range(0, 1));
      send_m(fmt_tab[$urandom_range(0, 7)], 7'($urandom()), 5'($urandom()), 5'($urandom()),
             5'($urandom()), 3'($urandom()), 7'($urandom()), imm, 1'b1);
    end
    out_ready = 1'b1;
    wait_drain();
    check_counters("random_sat");

    // reset with both stages full
    out_ready = 1'b0;
    send_m(3'b101, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'h0000_0010, 1'b0);
    send_m(3'b110, OPC_JAL, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    n_sent = 0;
    n_errs = 0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check_counters("midrst");
    out_ready = 1'b1;
    send(3'b000, OPC_OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'h0000_0005, {1'b0, 32'h0051_8113}, 1'b0);
    check_latency("latency_after_rst");
    wait_drain();
    check_counters("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
